// File: rtl/unidade_controle_genius_param.sv
// rtl/unidade_controle_genius_param.sv - Genius game control unit: FSM with address, round, show and timeout counters
module unidade_controle_genius_param #(
    parameter int ROUNDS         = 16,
    parameter int AW             = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SHOW_CYCLES    = 1000,
    parameter int LIVES          = 3,
    parameter int LW             = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          jogada,
    input  logic          jogada_correta,
    input  logic          modo,
    input  logic [1:0]    nivel,
    output logic [AW-1:0] endereco,
    output logic [AW-1:0] rodada,
    output logic          registraR,
    output logic          gravaRAM,
    output logic          exibe,
    output logic [LW-1:0] vidas,
    output logic          pronto,
    output logic          acertou,
    output logic          errou,
    output logic [3:0]    db_estado
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SHOW_CYCLES);

    localparam logic [TW-1:0] TIMEOUT_BASE = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SHOW_LAST    = SW'(SHOW_CYCLES - 1);
    localparam logic [AW-1:0] LAST_ROUND   = AW'(ROUNDS - 1);
    localparam logic [LW-1:0] LIVES_INIT   = LW'(LIVES);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ESPERA        = 4'h1,
        INICIO_RODADA = 4'h2,
        PREPARACAO    = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        CONFIG        = 4'h7,
        PROX_RODADA   = 4'h8,
        ESPERA_GRAVA  = 4'h9,
        MOSTRA        = 4'hA,
        TOUT          = 4'hB,
        GRAVA         = 4'hC,
        VITORIA       = 4'hD,
        DERROTA       = 4'hE,
        PERDE_VIDA    = 4'hF
    } state_t;

    state_t state;
    state_t nextState;

    logic [AW-1:0] addrCount;
    logic [SW-1:0] showTimer;
    logic [TW-1:0] waitTimer;
    logic          modoReg;
    logic [1:0]    nivelReg;

    logic [TW-1:0] timeoutLimit;
    logic [TW-1:0] timeoutLast;
    logic          timedOut;
    logic          showLast;
    logic          elementLast;

    // Higher difficulty halves the player window per level; a zero window degenerates to one cycle.
    assign timeoutLimit = TIMEOUT_BASE >> nivelReg;
    assign timeoutLast  = (timeoutLimit == '0) ? '0 : timeoutLimit - TW'(1);
    assign timedOut     = (waitTimer == timeoutLast);
    assign showLast     = (showTimer == SHOW_LAST);
    assign elementLast  = (addrCount == rodada);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INICIAL;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            INICIAL:       if (iniciar) nextState = PREPARACAO;
            PREPARACAO:    nextState = CONFIG;
            CONFIG:        nextState = INICIO_RODADA;
            INICIO_RODADA: nextState = MOSTRA;
            MOSTRA:        if (showLast && elementLast) nextState = ESPERA;
            ESPERA: begin
                if (timedOut) begin
                    nextState = TOUT;
                end else if (jogada) begin
                    nextState = REGISTRA;
                end
            end
            REGISTRA:      nextState = COMPARA;
            COMPARA: begin
                if (!jogada_correta) begin
                    nextState = PERDE_VIDA;
                end else if (addrCount < rodada) begin
                    nextState = PROX_JOGADA;
                end else if (rodada == LAST_ROUND) begin
                    nextState = VITORIA;
                end else begin
                    nextState = PROX_RODADA;
                end
            end
            PROX_JOGADA:   nextState = ESPERA;
            PROX_RODADA:   nextState = modoReg ? ESPERA_GRAVA : INICIO_RODADA;
            ESPERA_GRAVA: begin
                if (timedOut) begin
                    nextState = TOUT;
                end else if (jogada) begin
                    nextState = GRAVA;
                end
            end
            GRAVA:         nextState = INICIO_RODADA;
            PERDE_VIDA:    nextState = (vidas <= LW'(1)) ? DERROTA : INICIO_RODADA;
            VITORIA,
            DERROTA,
            TOUT:          if (iniciar) nextState = PREPARACAO;
            default:       nextState = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addrCount <= '0;
            rodada    <= '0;
            vidas     <= '0;
            showTimer <= '0;
            waitTimer <= '0;
            modoReg   <= 1'b0;
            nivelReg  <= 2'd0;
        end else begin
            case (state)
                PREPARACAO: begin
                    addrCount <= '0;
                    rodada    <= '0;
                    showTimer <= '0;
                    waitTimer <= '0;
                    vidas     <= LIVES_INIT;
                end
                CONFIG: begin
                    modoReg  <= modo;
                    nivelReg <= nivel;
                end
                INICIO_RODADA: begin
                    addrCount <= '0;
                    showTimer <= '0;
                    waitTimer <= '0;
                end
                MOSTRA: begin
                    if (showLast) begin
                        showTimer <= '0;
                        waitTimer <= '0;
                        addrCount <= elementLast ? '0 : addrCount + AW'(1);
                    end else begin
                        showTimer <= showTimer + SW'(1);
                    end
                end
                ESPERA,
                ESPERA_GRAVA: begin
                    if (!timedOut) begin
                        waitTimer <= waitTimer + TW'(1);
                    end
                end
                PROX_JOGADA: begin
                    addrCount <= addrCount + AW'(1);
                    waitTimer <= '0;
                end
                PROX_RODADA: begin
                    rodada    <= rodada + AW'(1);
                    waitTimer <= '0;
                end
                PERDE_VIDA: begin
                    if (vidas != '0) begin
                        vidas <= vidas - LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // While waiting for / writing the new element, the RAM is addressed by the round index.
    assign endereco  = (state == ESPERA_GRAVA || state == GRAVA) ? rodada : addrCount;
    assign registraR = (state == REGISTRA);
    assign gravaRAM  = (state == GRAVA);
    assign exibe     = (state == MOSTRA);
    assign pronto    = (state == VITORIA) || (state == DERROTA) || (state == TOUT);
    assign acertou   = (state == VITORIA);
    assign errou     = (state == DERROTA) || (state == TOUT);
    assign db_estado = state;

endmodule
